// File: rtl/mem_ext_loader.sv
// Host-side loader: turns a 32-bit header/payload word stream into instruction- and
// data-memory writes, data-memory readback, and control of the cpu enable.
module mem_ext_loader #(
  parameter int RD_LAT = 1,
  parameter int CNT_W  = 14
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        busy,
  output logic        cpu_enable,
  output logic [63:0] imem_addr_ext,
  output logic        imem_wen_ext,
  output logic        imem_ren_ext,
  output logic [31:0] imem_wdata_ext,
  output logic [63:0] dmem_addr_ext,
  output logic        dmem_wen_ext,
  output logic        dmem_ren_ext,
  output logic [63:0] dmem_wdata_ext,
  input  logic [63:0] dmem_rdata_ext
);

  localparam int LAT_W = $clog2(RD_LAT + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_I,
    LOAD_D_LO,
    LOAD_D_HI,
    RD_REQ,
    RD_WAIT,
    RD_OUT
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [63:0]        nxt_q, nxt_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic [31:0]        lo_q, lo_d;
  logic               cpu_en_q, cpu_en_d;
  logic [63:0]        imem_addr_q, imem_addr_d;
  logic [31:0]        imem_wdata_q, imem_wdata_d;
  logic               imem_wen_q, imem_wen_d;
  logic [63:0]        dmem_addr_q, dmem_addr_d;
  logic [63:0]        dmem_wdata_q, dmem_wdata_d;
  logic               dmem_wen_q, dmem_wen_d;
  logic               dmem_ren_q, dmem_ren_d;
  logic               out_valid_q, out_valid_d;
  logic [63:0]        out_data_q, out_data_d;
  logic               live_q;
  logic               beat;
  logic [1:0]         hdr_cmd;
  logic [CNT_W-1:0]   hdr_cnt;

  // live_q keeps in_ready low while reset is asserted and for the release edge itself.
  assign in_ready = live_q && (state_q == IDLE || state_q == LOAD_I ||
                               state_q == LOAD_D_LO || state_q == LOAD_D_HI);
  assign beat     = in_valid && in_ready;
  assign hdr_cmd  = in_data[31:30];
  assign hdr_cnt  = in_data[16 +: CNT_W];

  assign busy           = (state_q != IDLE);
  assign cpu_enable     = cpu_en_q;
  assign imem_addr_ext  = imem_addr_q;
  assign imem_wen_ext   = imem_wen_q;
  assign imem_ren_ext   = 1'b0;
  assign imem_wdata_ext = imem_wdata_q;
  assign dmem_addr_ext  = dmem_addr_q;
  assign dmem_wen_ext   = dmem_wen_q;
  assign dmem_ren_ext   = dmem_ren_q;
  assign dmem_wdata_ext = dmem_wdata_q;
  assign out_valid      = out_valid_q;
  assign out_data       = out_data_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    nxt_d        = nxt_q;
    lat_d        = lat_q;
    lo_d         = lo_q;
    cpu_en_d     = cpu_en_q;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    imem_wen_d   = 1'b0;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    dmem_wen_d   = 1'b0;
    dmem_ren_d   = 1'b0;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;

    unique case (state_q)
      IDLE: begin
        if (beat) begin
          if (hdr_cmd == 2'b11) begin
            cpu_en_d = (hdr_cnt != '0);
          end else begin
            // Any memory command stops the cpu first so it never races the loader.
            cpu_en_d = 1'b0;
            cnt_d    = hdr_cnt;
            if (hdr_cmd == 2'b00) nxt_d = {46'd0, in_data[15:0], 2'b00};
            else                  nxt_d = {45'd0, in_data[15:0], 3'b000};
            if (hdr_cnt != '0) begin
              unique case (hdr_cmd)
                2'b00:   state_d = LOAD_I;
                2'b01:   state_d = LOAD_D_LO;
                default: state_d = RD_REQ;
              endcase
            end
          end
        end
      end
      LOAD_I: begin
        if (beat) begin
          imem_addr_d  = nxt_q;
          imem_wdata_d = in_data;
          imem_wen_d   = 1'b1;
          nxt_d        = nxt_q + 64'd4;
          cnt_d        = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) state_d = IDLE;
        end
      end
      LOAD_D_LO: begin
        if (beat) begin
          lo_d    = in_data;
          state_d = LOAD_D_HI;
        end
      end
      LOAD_D_HI: begin
        if (beat) begin
          dmem_addr_d  = nxt_q;
          dmem_wdata_d = {in_data, lo_q};
          dmem_wen_d   = 1'b1;
          nxt_d        = nxt_q + 64'd8;
          cnt_d        = cnt_q - 1'b1;
          state_d      = (cnt_q == CNT_W'(1)) ? IDLE : LOAD_D_LO;
        end
      end
      RD_REQ: begin
        dmem_ren_d  = 1'b1;
        dmem_addr_d = nxt_q;
        nxt_d       = nxt_q + 64'd8;
        lat_d       = LAT_W'(RD_LAT);
        state_d     = RD_WAIT;
      end
      RD_WAIT: begin
        // The strobe leaves the register one cycle after RD_REQ, so the count starts there.
        if (lat_q == '0) begin
          out_data_d  = dmem_rdata_ext;
          out_valid_d = 1'b1;
          state_d     = RD_OUT;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      RD_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          cnt_d       = cnt_q - 1'b1;
          state_d     = (cnt_q == CNT_W'(1)) ? IDLE : RD_REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      live_q       <= 1'b0;
      cnt_q        <= '0;
      nxt_q        <= '0;
      lat_q        <= '0;
      lo_q         <= '0;
      cpu_en_q     <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      imem_wen_q   <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      dmem_wen_q   <= 1'b0;
      dmem_ren_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
    end else begin
      live_q       <= 1'b1;
      cnt_q        <= cnt_d;
      nxt_q        <= nxt_d;
      lat_q        <= lat_d;
      lo_q         <= lo_d;
      cpu_en_q     <= cpu_en_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      imem_wen_q   <= imem_wen_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      dmem_wen_q   <= dmem_wen_d;
      dmem_ren_q   <= dmem_ren_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
    end
  end

endmodule

// File: tb/tb_mem_ext_loader.sv
// Directed bench for mem_ext_loader: drives header/payload words, models a small data
// memory with one-cycle read latency and logs every memory strobe for comparison.
module tb_mem_ext_loader;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_data;
  logic        busy;
  logic        cpu_enable;
  logic [63:0] imem_addr_ext;
  logic        imem_wen_ext;
  logic        imem_ren_ext;
  logic [31:0] imem_wdata_ext;
  logic [63:0] dmem_addr_ext;
  logic        dmem_wen_ext;
  logic        dmem_ren_ext;
  logic [63:0] dmem_wdata_ext;
  logic [63:0] dmem_rdata_ext = '0;

  int checkCount = 0;
  int passCount  = 0;

  logic [63:0] iAddrQ[$];
  logic [31:0] iDataQ[$];
  logic [63:0] dAddrQ[$];
  logic [63:0] dDataQ[$];
  int          renCount = 0;
  logic        overlapSeen = 1'b0;
  logic [63:0] dmem [16];

  mem_ext_loader dut (
    .clk(clk), .arst_n(arst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .cpu_enable(cpu_enable),
    .imem_addr_ext(imem_addr_ext), .imem_wen_ext(imem_wen_ext),
    .imem_ren_ext(imem_ren_ext), .imem_wdata_ext(imem_wdata_ext),
    .dmem_addr_ext(dmem_addr_ext), .dmem_wen_ext(dmem_wen_ext),
    .dmem_ren_ext(dmem_ren_ext), .dmem_wdata_ext(dmem_wdata_ext),
    .dmem_rdata_ext(dmem_rdata_ext)
  );

  always #5 clk = ~clk;

  // Data memory: synchronous write, registered read one cycle after the strobe.
  always @(posedge clk) begin
    if (dmem_wen_ext) dmem[dmem_addr_ext[6:3]] <= dmem_wdata_ext;
    if (dmem_ren_ext) dmem_rdata_ext <= dmem[dmem_addr_ext[6:3]];
  end

  // Strobe logger, sampled mid-cycle.
  always @(negedge clk) begin
    if (imem_wen_ext) begin
      iAddrQ.push_back(imem_addr_ext);
      iDataQ.push_back(imem_wdata_ext);
    end
    if (dmem_wen_ext) begin
      dAddrQ.push_back(dmem_addr_ext);
      dDataQ.push_back(dmem_wdata_ext);
    end
    if (dmem_ren_ext) renCount++;
    if ((dmem_wen_ext && dmem_ren_ext) || imem_ren_ext) overlapSeen = 1'b1;
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic waitNeg(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  // Presents one word and returns at the negedge after it was consumed (in_valid stays high).
  task automatic applyStimulus(input logic [31:0] word);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    in_data  = word;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) checkOutput("in_ready_timeout", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
  endtask

  task automatic waitOutValid(input string tag);
    int guard;
    guard = 0;
    while (!out_valid && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    checkOutput(tag, {63'd0, out_valid}, 64'd1);
  endtask

  function automatic logic [63:0] iAddrAt(input int i);
    return (iAddrQ.size() > i) ? iAddrQ[i] : '1;
  endfunction

  function automatic logic [63:0] iDataAt(input int i);
    return (iDataQ.size() > i) ? {32'd0, iDataQ[i]} : '1;
  endfunction

  initial begin
    for (int k = 0; k < 16; k++) dmem[k] = '0;

    // Reset state
    waitNeg(2);
    checkOutput("rst_in_ready", {63'd0, in_ready}, 64'd0);
    checkOutput("rst_busy", {63'd0, busy}, 64'd0);
    checkOutput("rst_cpu_en", {63'd0, cpu_enable}, 64'd0);
    checkOutput("rst_imem_wen", {63'd0, imem_wen_ext}, 64'd0);
    checkOutput("rst_dmem_ren", {63'd0, dmem_ren_ext}, 64'd0);
    checkOutput("rst_out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("rst_imem_addr", imem_addr_ext, 64'd0);
    arst_n = 1'b1;
    waitNeg(1);
    checkOutput("post_rst_ready", {63'd0, in_ready}, 64'd1);

    // T1: three instruction words back to back
    applyStimulus(32'h0003_0000);
    checkOutput("t1_busy_hdr", {63'd0, busy}, 64'd1);
    applyStimulus(32'hA0A0_0001);
    applyStimulus(32'hB0B0_0002);
    applyStimulus(32'hC0C0_0003);
    in_valid = 1'b0;
    waitNeg(3);
    checkOutput("t1_count", 64'(iAddrQ.size()), 64'd3);
    checkOutput("t1_addr0", iAddrAt(0), 64'h0);
    checkOutput("t1_addr1", iAddrAt(1), 64'h4);
    checkOutput("t1_addr2", iAddrAt(2), 64'h8);
    checkOutput("t1_data0", iDataAt(0), 64'hA0A0_0001);
    checkOutput("t1_data2", iDataAt(2), 64'hC0C0_0003);
    checkOutput("t1_busy_end", {63'd0, busy}, 64'd0);

    // T2: one 64-bit data word at index 2
    applyStimulus(32'h4001_0002);
    applyStimulus(32'h1111_1111);
    applyStimulus(32'h2222_2222);
    in_valid = 1'b0;
    waitNeg(3);
    checkOutput("t2_count", 64'(dAddrQ.size()), 64'd1);
    checkOutput("t2_addr", (dAddrQ.size() > 0) ? dAddrQ[0] : '1, 64'h10);
    checkOutput("t2_data", (dDataQ.size() > 0) ? dDataQ[0] : '1, 64'h2222_2222_1111_1111);

    // T3: preload words 2..3, read them back with a stalled host
    applyStimulus(32'h4002_0002);
    applyStimulus(32'h4444_4444);
    applyStimulus(32'h3333_3333);
    applyStimulus(32'h6666_6666);
    applyStimulus(32'h5555_5555);
    in_valid = 1'b0;
    waitNeg(2);
    renCount = 0;
    applyStimulus(32'h8002_0002);
    in_valid = 1'b0;
    waitOutValid("t3_valid0");
    checkOutput("t3_word0", out_data, 64'h3333_3333_4444_4444);
    waitNeg(5);
    checkOutput("t3_hold_valid", {63'd0, out_valid}, 64'd1);
    checkOutput("t3_hold_data", out_data, 64'h3333_3333_4444_4444);
    checkOutput("t3_no_ready", {63'd0, in_ready}, 64'd0);
    out_ready = 1'b1;
    waitNeg(1);
    waitOutValid("t3_valid1");
    checkOutput("t3_word1", out_data, 64'h5555_5555_6666_6666);
    waitNeg(1);
    out_ready = 1'b0;
    waitNeg(2);
    checkOutput("t3_ren_count", 64'(renCount), 64'd2);
    checkOutput("t3_idle", {63'd0, busy}, 64'd0);
    checkOutput("t3_out_drop", {63'd0, out_valid}, 64'd0);

    // T4: run control
    applyStimulus(32'hC001_0000);
    in_valid = 1'b0;
    checkOutput("t4_run_on", {63'd0, cpu_enable}, 64'd1);
    waitNeg(1);
    applyStimulus(32'hC000_0000);
    in_valid = 1'b0;
    checkOutput("t4_run_off", {63'd0, cpu_enable}, 64'd0);
    applyStimulus(32'hC005_0000);
    in_valid = 1'b0;
    checkOutput("t4_run_on2", {63'd0, cpu_enable}, 64'd1);
    iAddrQ.delete();
    iDataQ.delete();
    applyStimulus(32'h0001_0000);
    checkOutput("t4_hdr_clears", {63'd0, cpu_enable}, 64'd0);
    applyStimulus(32'hDEAD_BEEF);
    in_valid = 1'b0;
    waitNeg(2);
    checkOutput("t4_iwrite", iDataAt(0), 64'hDEAD_BEEF);

    // T5: gap between halves, then zero-count headers
    dAddrQ.delete();
    dDataQ.delete();
    applyStimulus(32'h4001_0005);
    applyStimulus(32'hAAAA_0001);
    in_valid = 1'b0;
    waitNeg(3);
    checkOutput("t5_no_early_wr", 64'(dAddrQ.size()), 64'd0);
    checkOutput("t5_busy_gap", {63'd0, busy}, 64'd1);
    applyStimulus(32'hBBBB_0002);
    in_valid = 1'b0;
    waitNeg(3);
    checkOutput("t5_count", 64'(dAddrQ.size()), 64'd1);
    checkOutput("t5_addr", (dAddrQ.size() > 0) ? dAddrQ[0] : '1, 64'h28);
    checkOutput("t5_data", (dDataQ.size() > 0) ? dDataQ[0] : '1, 64'hBBBB_0002_AAAA_0001);
    iAddrQ.delete();
    applyStimulus(32'h4000_0007);
    applyStimulus(32'h0000_0009);
    applyStimulus(32'h8000_0001);
    in_valid = 1'b0;
    waitNeg(3);
    checkOutput("t5_n0_dwr", 64'(dAddrQ.size()), 64'd1);
    checkOutput("t5_n0_iwr", 64'(iAddrQ.size()), 64'd0);
    checkOutput("t5_n0_busy", {63'd0, busy}, 64'd0);
    checkOutput("t5_n0_outv", {63'd0, out_valid}, 64'd0);

    // T6: asynchronous reset during the second of four instruction words
    iAddrQ.delete();
    iDataQ.delete();
    applyStimulus(32'h0004_0010);
    applyStimulus(32'h0101_0101);
    in_data = 32'h0202_0202;
    #2 arst_n = 1'b0;
    @(negedge clk);
    checkOutput("t6_busy", {63'd0, busy}, 64'd0);
    checkOutput("t6_imem_wen", {63'd0, imem_wen_ext}, 64'd0);
    checkOutput("t6_imem_addr", imem_addr_ext, 64'd0);
    checkOutput("t6_imem_wdata", {32'd0, imem_wdata_ext}, 64'd0);
    checkOutput("t6_in_ready", {63'd0, in_ready}, 64'd0);
    in_valid = 1'b0;
    arst_n   = 1'b1;
    waitNeg(1);
    checkOutput("t6_ready_back", {63'd0, in_ready}, 64'd1);
    checkOutput("t6_one_write", 64'(iAddrQ.size()), 64'd1);
    checkOutput("t6_addr_pre", iAddrAt(0), 64'h40);
    iAddrQ.delete();
    iDataQ.delete();
    applyStimulus(32'h0001_0020);
    applyStimulus(32'h0303_0303);
    in_valid = 1'b0;
    waitNeg(3);
    checkOutput("t6_new_addr", iAddrAt(0), 64'h80);
    checkOutput("t6_new_data", iDataAt(0), 64'h0303_0303);

    checkOutput("strobe_excl", {63'd0, overlapSeen}, 64'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
